// File: rtl/rect_geom_if.sv
// Valid/ready operand and result channel for rect_geom_unit.
// The is_square member exists only when RECT_SQUARE_FLAG_EN is defined.
interface rect_geom_if #(
    parameter int W = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   l;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [W+1:0]   perimeter;
    logic [2*W-1:0] area;
    logic           busy;
`ifdef RECT_SQUARE_FLAG_EN
    logic           is_square;

    modport master (
        output in_valid, l, b, out_ready,
        input  in_ready, out_valid, perimeter, area, busy, is_square
    );
    modport slave (
        input  in_valid, l, b, out_ready,
        output in_ready, out_valid, perimeter, area, busy, is_square
    );
`else
    modport master (
        output in_valid, l, b, out_ready,
        input  in_ready, out_valid, perimeter, area, busy
    );
    modport slave (
        input  in_valid, l, b, out_ready,
        output in_ready, out_valid, perimeter, area, busy
    );
`endif
endinterface

// File: rtl/rect_geom_unit.sv
// Handshaked rectangle perimeter/area unit; area from a one-bit-per-cycle shift-add multiplier.
// Optional feature macro: RECT_SQUARE_FLAG_EN (adds is_square, registered at accept).
module rect_geom_unit #(
    parameter int W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    rect_geom_if.slave  io
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg;
    logic [2*W-1:0]  mcand_reg;
    logic [W-1:0]    mplier_reg;
    logic [CW-1:0]   cnt_reg;
    logic [W:0]      sum_next;

    assign sum_next = {1'b0, io.l} + {1'b0, io.b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.busy      <= 1'b0;
            io.perimeter <= '0;
            io.area      <= '0;
`ifdef RECT_SQUARE_FLAG_EN
            io.is_square <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io.in_valid) begin
                        mcand_reg    <= {{W{1'b0}}, io.l};
                        mplier_reg   <= io.b;
                        cnt_reg      <= '0;
                        io.area      <= '0;
                        io.perimeter <= {sum_next, 1'b0};
`ifdef RECT_SQUARE_FLAG_EN
                        io.is_square <= (io.l == io.b);
`endif
                        io.in_ready  <= 1'b0;
                        io.busy      <= 1'b1;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    // area doubles as the accumulator; it is only meaningful once out_valid rises
                    if (mplier_reg[0]) begin
                        io.area <= io.area + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        io.busy      <= 1'b0;
                        io.out_valid <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rect_geom_unit.sv
// Randomised and directed bench for rect_geom_unit at W=3 and W=8 against an arithmetic reference.
// Honours RECT_SQUARE_FLAG_EN by also checking is_square.
module tb_rect_geom_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst8_n = 1'b0;
    int vec_cnt = 0;
    int miscompare_cnt = 0;

    always #5 clk = ~clk;

    rect_geom_if #(.W(3)) if3 ();
    rect_geom_if #(.W(8)) if8 ();

    rect_geom_unit #(.W(3)) dut3 (.clk(clk), .rst_n(rst_n),  .io(if3.slave));
    rect_geom_unit #(.W(8)) dut8 (.clk(clk), .rst_n(rst8_n), .io(if8.slave));

    task automatic check(input string tag, input longint obs, input longint exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=3 transaction; hold = number of cycles out_ready is held low in DONE.
    task automatic run3(input int lv, input int bv, input int hold);
        int edges;
        int exp_per;
        int exp_area;
        int t;
        exp_per  = 2 * (lv + bv);
        exp_area = lv * bv;
        t = 0;
        while (!if3.in_ready && t < 30) begin
            tick();
            t++;
        end
        check("in_ready_wait", longint'(if3.in_ready), 1);
        if3.l = 3'(lv);
        if3.b = 3'(bv);
        if3.in_valid  = 1'b1;
        if3.out_ready = (hold == 0);
        tick();
        edges = 1;
        check("busy_after_accept", longint'(if3.busy), 1);
        check("in_ready_busy", longint'(if3.in_ready), 0);
        // junk offered while busy must be ignored
        if3.l = 3'($urandom_range(0, 7));
        if3.b = 3'($urandom_range(0, 7));
        while (!if3.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        if3.in_valid = 1'b0;
        check("latency3", edges, 4);
        check("perimeter3", longint'(if3.perimeter), exp_per);
        check("area3", longint'(if3.area), exp_area);
`ifdef RECT_SQUARE_FLAG_EN
        check("is_square3", longint'(if3.is_square), longint'(lv == bv));
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_out_valid", longint'(if3.out_valid), 1);
            check("bp_perimeter", longint'(if3.perimeter), exp_per);
            check("bp_area", longint'(if3.area), exp_area);
        end
        if3.out_ready = 1'b1;
        tick();
        check("hs_out_valid", longint'(if3.out_valid), 0);
        check("hs_in_ready", longint'(if3.in_ready), 1);
        if3.out_ready = 1'b0;
    endtask

    task automatic run8(input int lv, input int bv);
        int edges;
        int t;
        t = 0;
        while (!if8.in_ready && t < 30) begin
            tick();
            t++;
        end
        check("in_ready8_wait", longint'(if8.in_ready), 1);
        if8.l = 8'(lv);
        if8.b = 8'(bv);
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b1;
        tick();
        edges = 1;
        if8.in_valid = 1'b0;
        while (!if8.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check("latency8", edges, 9);
        check("perimeter8", longint'(if8.perimeter), 2 * (lv + bv));
        check("area8", longint'(if8.area), lv * bv);
        tick();
        check("hs8_out_valid", longint'(if8.out_valid), 0);
        if8.out_ready = 1'b0;
    endtask

    initial begin
        if3.in_valid = 1'b0; if3.out_ready = 1'b0; if3.l = '0; if3.b = '0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.l = '0; if8.b = '0;
        tick();
        tick();
        check("rst_in_ready", longint'(if3.in_ready), 1);
        check("rst_out_valid", longint'(if3.out_valid), 0);
        check("rst_busy", longint'(if3.busy), 0);
        check("rst_perimeter", longint'(if3.perimeter), 0);
        check("rst_area", longint'(if3.area), 0);
        rst_n = 1'b1;
        rst8_n = 1'b1;
        tick();

        run3(3, 1, 0);
        run3(5, 3, 0);
        run3(7, 4, 0);
        run3(6, 2, 0);
        run3(7, 7, 10);
        run3(0, 5, 0);
        run3(7, 0, 1);

        // reset two cycles after accepting (6,5)
        if3.l = 3'd6; if3.b = 3'd5; if3.in_valid = 1'b1; if3.out_ready = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", longint'(if3.in_ready), 1);
        check("mid_rst_out_valid", longint'(if3.out_valid), 0);
        check("mid_rst_busy", longint'(if3.busy), 0);
        check("mid_rst_perimeter", longint'(if3.perimeter), 0);
        check("mid_rst_area", longint'(if3.area), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_valid", longint'(if3.out_valid), 0);
        end
        if3.out_ready = 1'b0;
        run3(2, 2, 0);

        for (int i = 0; i < 20; i++) begin
            run3(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        run8(255, 255);
        run8(0, 200);
        for (int i = 0; i < 6; i++) begin
            run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end
endmodule
